// File: rtl/com_fifo_pkg.sv
// rtl/com_fifo_pkg.sv - shared sizing helpers for the com_fifo family of blocks
package com_fifo_pkg;

  localparam int COM_FIFO_DEFAULT_DW = 32;

  // Smallest prefetch buffer that sustains one beat per cycle for a given RAM latency.
  function automatic int COM_FIFO_PREFETCH_MIN_DEPTH(input int lat);
    return lat + 2;
  endfunction

  function automatic int F_cntw(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/com_prefetch_buf.sv
// rtl/com_prefetch_buf.sv - DEPTH x DW register skid buffer with push/pop/clear and entry count
module com_prefetch_buf
  import com_fifo_pkg::*;
#(
  parameter int DW    = COM_FIFO_DEFAULT_DW,
  parameter int DEPTH = 3,
  parameter int CW    = F_cntw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [CW-1:0] cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Explicit wrap keeps non-power-of-2 depths legal.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/com_fifo_rd_prefetch.sv
// rtl/com_fifo_rd_prefetch.sv - credit-based read prefetch hiding RAM latency behind a valid/ready stream
// Optional o_level port and level logic under `COM_FIFO_PREFETCH_LEVEL_EN.
module com_fifo_rd_prefetch
  import com_fifo_pkg::*;
#(
  parameter int DW        = COM_FIFO_DEFAULT_DW,
  parameter int RD_LAT    = 1,
  parameter int BUF_DEPTH = COM_FIFO_PREFETCH_MIN_DEPTH(RD_LAT),
  parameter int CW        = F_cntw(BUF_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          fifo_empty,
  output logic          fifo_rd_en,
  input  logic [DW-1:0] mem_rdata,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
`ifdef COM_FIFO_PREFETCH_LEVEL_EN
  output logic [CW-1:0] o_level,
`endif
  input  logic          i_ready
);

  localparam int IW = F_cntw(RD_LAT);

  if (RD_LAT < 1) begin : g_bad_lat
    $error("com_fifo_rd_prefetch: RD_LAT must be >= 1");
  end
  if (BUF_DEPTH < RD_LAT + 1) begin : g_bad_depth
    $error("com_fifo_rd_prefetch: BUF_DEPTH must be >= RD_LAT+1");
  end

  logic [RD_LAT-1:0] pipe;
  logic [RD_LAT-1:0] pipe_next;
  logic [IW-1:0]     inflight;
  logic [CW-1:0]     buf_cnt;
  logic [CW:0]       occupancy;
  logic              tail;
  logic              push;
  logic              pop;

  assign tail      = pipe[RD_LAT-1];
  assign occupancy = (CW+1)'(inflight) + (CW+1)'(buf_cnt);

  // Credit counts reads already issued, so the buffer can never overflow when data lands.
  assign fifo_rd_en = rst_n && !fifo_empty && !clear && (occupancy < (CW+1)'(BUF_DEPTH));

  assign o_valid = (buf_cnt != '0) && !clear;
  assign push    = tail && !clear;
  assign pop     = o_valid && i_ready;

  if (RD_LAT == 1) begin : g_pipe1
    assign pipe_next = fifo_rd_en;
  end else begin : g_pipen
    assign pipe_next = {pipe[RD_LAT-2:0], fifo_rd_en};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe     <= '0;
      inflight <= '0;
    end else if (clear) begin
      pipe     <= '0;
      inflight <= '0;
    end else begin
      pipe <= pipe_next;
      case ({fifo_rd_en, tail})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  com_prefetch_buf #(
    .DW    (DW),
    .DEPTH (BUF_DEPTH),
    .CW    (CW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (push),
    .push_data (mem_rdata),
    .pop       (pop),
    .head      (o_data),
    .cnt       (buf_cnt)
  );

`ifdef COM_FIFO_PREFETCH_LEVEL_EN
  assign o_level = buf_cnt;
`endif

  rd_when_empty_a: assert property (@(posedge clk) disable iff (!rst_n) !(fifo_rd_en && fifo_empty));

endmodule

// File: tb/tb_com_fifo_rd_prefetch.sv
// tb/tb_com_fifo_rd_prefetch.sv - self-checking bench for com_fifo_rd_prefetch (RD_LAT=1 and RD_LAT=3 instances)
`timescale 1ns/1ps
module tb_com_fifo_rd_prefetch;

  logic        clk = 1'b0;
  logic        rst_n, clear, i_ready, use3, fe_raw, tog, tog_mode, rnd_mode;
  logic        fifo_empty1, fifo_empty3, rd1, rd3, v1, v3;
  logic [31:0] mem1, mem3, d1, d3;
`ifdef COM_FIFO_PREFETCH_LEVEL_EN
  logic [1:0]  lvl1;
  logic [2:0]  lvl3;
`endif

  always #5 clk = ~clk;

  // Only the selected instance sees a non-empty FIFO.
  assign fifo_empty1 = use3 | fe_raw;
  assign fifo_empty3 = !use3 | fe_raw;

  com_fifo_rd_prefetch #(.DW(32), .RD_LAT(1), .BUF_DEPTH(3)) u1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .fifo_empty(fifo_empty1),
    .fifo_rd_en(rd1), .mem_rdata(mem1), .o_valid(v1), .o_data(d1),
`ifdef COM_FIFO_PREFETCH_LEVEL_EN
    .o_level(lvl1),
`endif
    .i_ready(i_ready)
  );

  com_fifo_rd_prefetch #(.DW(32), .RD_LAT(3), .BUF_DEPTH(5)) u3 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .fifo_empty(fifo_empty3),
    .fifo_rd_en(rd3), .mem_rdata(mem3), .o_valid(v3), .o_data(d3),
`ifdef COM_FIFO_PREFETCH_LEVEL_EN
    .o_level(lvl3),
`endif
    .i_ready(i_ready)
  );

  typedef struct { logic [31:0] d; int t; } ent_t;

  logic [31:0] src_mem [0:31];
  logic [31:0] dl [0:2];
  int          avail, rd_idx, rd_count, bad_rd;
  ent_t        q[$];
  logic [31:0] out_log[$];
  int          out_cyc[$];
  int          mcyc, m_idx, first_rd, first_v;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Model: every issued word is owed to the consumer, in order, RD_LAT+1 cycles after issue.
  always @(negedge clk) begin
    logic        a_rd, a_v, a_fe, e_rd, e_v;
    logic [31:0] a_d;
    int          depth, lat;
    ent_t        e;
    if (!rst_n) begin
      q.delete(); out_log.delete(); out_cyc.delete();
      mcyc = 0; m_idx = 0; first_rd = -1; first_v = -1;
    end else begin
      depth = use3 ? 5 : 3;
      lat   = use3 ? 3 : 1;
      a_rd  = use3 ? rd3 : rd1;
      a_v   = use3 ? v3 : v1;
      a_d   = use3 ? d3 : d1;
      a_fe  = use3 ? fifo_empty3 : fifo_empty1;
      e_rd  = !a_fe && !clear && (q.size() < depth);
      e_v   = 1'b0;
      if (!clear && q.size() > 0) e_v = (mcyc >= q[0].t + lat + 1);
      chk("rd_en", a_rd, e_rd);
      chk("valid", a_v, e_v);
      if (e_v && a_v) chk("data", a_d, q[0].d);
      if (a_rd && first_rd < 0) first_rd = mcyc;
      if (a_v && first_v < 0) first_v = mcyc;
      if (clear) q.delete();
      else begin
        if (a_v && i_ready) begin
          out_log.push_back(a_d);
          out_cyc.push_back(mcyc);
        end
        if (e_v && i_ready) void'(q.pop_front());
        if (a_rd && m_idx < 32) begin
          e.d = src_mem[m_idx];
          e.t = mcyc;
          q.push_back(e);
          m_idx++;
        end
      end
      mcyc++;
    end
  end

  task automatic upd_fe();
    fe_raw = (rd_idx >= avail) || tog;
  endtask

  // One clock: sample issue at negedge, then advance the RAM delay line after the edge.
  task automatic tick();
    logic s_rd, s_fe;
    @(negedge clk);
    s_rd = use3 ? rd3 : rd1;
    s_fe = use3 ? fifo_empty3 : fifo_empty1;
    if (s_rd) rd_count++;
    if (s_rd && s_fe) bad_rd++;
    @(posedge clk);
    #1;
    dl[2] = dl[1];
    dl[1] = dl[0];
    if (s_rd && rd_idx < 32) begin
      dl[0] = src_mem[rd_idx];
      rd_idx++;
    end else dl[0] = 32'hdead_beef;
    mem1 = dl[0];
    mem3 = dl[2];
    if (tog_mode) tog = !tog;
    if (rnd_mode) i_ready = 1'($urandom_range(0, 1));
    upd_fe();
  endtask

  task automatic start(input logic sel3, input int base, input int av, input logic rdy);
    rst_n = 1'b0; clear = 1'b0; tog_mode = 1'b0; tog = 1'b0; rnd_mode = 1'b0;
    i_ready = rdy; use3 = sel3;
    for (int i = 0; i < 32; i++) src_mem[i] = 32'(base + i);
    avail = av; rd_idx = 0; rd_count = 0; bad_rd = 0;
    for (int i = 0; i < 3; i++) dl[i] = '0;
    mem1 = '0; mem3 = '0;
    upd_fe();
    tick();
    tick();
  endtask

  task automatic wait_out(input int n, input int budget, input string nm);
    for (int i = 0; i < budget && out_log.size() < n; i++) tick();
    chk(nm, out_log.size(), n);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; i_ready = 1'b0; use3 = 1'b0;
    tog = 1'b0; tog_mode = 1'b0; rnd_mode = 1'b0; fe_raw = 1'b1;

    // 1: reset with a non-empty FIFO
    start(1'b0, 0, 8, 1'b1);
    chk("t1_rd_en", rd1, 0);
    chk("t1_valid", v1, 0);
    chk("t1_data", d1, 0);

    // 2: streaming 0..7, RD_LAT=1
    rst_n = 1'b1;
    wait_out(8, 40, "t2_count");
    chk("t2_latency", first_v - first_rd, 2);
    for (int i = 0; i < out_log.size() && i < 8; i++) chk("t2_data", out_log[i], i);
    if (out_log.size() == 8) chk("t2_back_to_back", out_cyc[7] - out_cyc[0], 7);

    // 3: consumer stalled, credit limits issue to BUF_DEPTH
    start(1'b0, 0, 10, 1'b0);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("t3_reads", rd_count, 3);
    chk("t3_valid", v1, 1);
    chk("t3_head", d1, 0);
    repeat (5) tick();
    chk("t3_hold", d1, 0);
    chk("t3_rd_en", rd1, 0);
    i_ready = 1'b1;
    wait_out(10, 40, "t3_count");
    for (int i = 0; i < out_log.size() && i < 10; i++) chk("t3_data", out_log[i], i);
    repeat (5) tick();
    chk("t3_no_dup", out_log.size(), 10);

    // 4: toggling empty, random ready
    start(1'b0, 100, 20, 1'b1);
    rst_n = 1'b1;
    tog_mode = 1'b1;
    rnd_mode = 1'b1;
    wait_out(20, 400, "t4_count");
    for (int i = 0; i < out_log.size() && i < 20; i++) chk("t4_data", out_log[i], 100 + i);
    chk("t4_rd_while_empty", bad_rd, 0);

    // 5: clear with two reads in flight and one buffered, RD_LAT=3
    start(1'b1, 200, 1, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 10 && rd_count < 1; i++) tick();
    repeat (5) tick();
    chk("t5_buffered", v3, 1);
    chk("t5_head", d3, 200);
    avail = 3;
    upd_fe();
    for (int i = 0; i < 10 && rd_count < 3; i++) tick();
    chk("t5_reads", rd_count, 3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5_valid_after_clear", v3, 0);
    avail = 10;
    upd_fe();
    i_ready = 1'b1;
    wait_out(3, 40, "t5_count");
    for (int i = 0; i < out_log.size() && i < 3; i++) chk("t5_data", out_log[i], 203 + i);

    // 6: RD_LAT=3 fill to BUF_DEPTH, single pop frees one credit
    start(1'b1, 300, 12, 1'b0);
    rst_n = 1'b1;
    repeat (15) tick();
    chk("t6_reads", rd_count, 5);
    chk("t6_rd_en", rd3, 0);
    chk("t6_head", d3, 300);
`ifdef COM_FIFO_PREFETCH_LEVEL_EN
    chk("t6_level_full", lvl3, 5);
`endif
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk("t6_head_after_pop", d3, 301);
    chk("t6_rd_en_after_pop", rd3, 1);
`ifdef COM_FIFO_PREFETCH_LEVEL_EN
    chk("t6_level_after_pop", lvl3, 4);
`endif
    tick();
    chk("t6_reads_after_pop", rd_count, 6);
    repeat (6) tick();
    chk("t6_reads_final", rd_count, 6);
`ifdef COM_FIFO_PREFETCH_LEVEL_EN
    chk("t6_level_refill", lvl3, 5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
